// File: rtl/slotmaker_config_store.sv
// slotmaker_config_store
// Slot-side responder for the slotmaker configuration channel. Keeps a
// staged card ID per Apple II slot (0-7), lets the controller write and
// read it back, and on a reconfig request walks the slots one per cycle,
// copying staged IDs into the active table and strobing every slot whose
// active ID changed.

module slotmaker_config_store #(
    parameter logic [63:0] DEFAULT_CARDS = 64'h0,
    parameter logic [7:0]  FIXED_MASK    = 8'h00
) (
    input  logic        clk_logic,
    input  logic        system_reset_n,
    input  logic [2:0]  slot,
    input  logic        wr,
    input  logic [7:0]  card_i,
    output logic [7:0]  card_o,
    input  logic        reconfig,
    output logic        busy_o,
    output logic        commit_done_o,
    output logic        slot_change_o,
    output logic [2:0]  slot_change_slot_o,
    output logic [7:0]  slot_change_card_o,
    output logic [63:0] active_cards_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [7:0] staged_q [8];
    logic [7:0] staged_d [8];
    logic [7:0] active_q [8];
    logic [7:0] active_d [8];

    logic [1:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       pending_q, pending_d;
    logic [7:0] card_q, card_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       chg_q, chg_d;
    logic [2:0] chg_slot_q, chg_slot_d;
    logic [7:0] chg_card_q, chg_card_d;

    logic       wr_en;
    logic [7:0] scan_src;

    // Writes to read-only slots are dropped here so every consumer sees the same qualifier.
    assign wr_en = wr && !FIXED_MASK[slot];

    // A write landing on the slot being scanned this edge is forwarded so the commit picks it up.
    assign scan_src = (wr_en && (slot == idx_q)) ? card_i : staged_q[idx_q];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slot
            // Next staged value per slot: take the write data when this slot is addressed.
            always_comb begin
                staged_d[gi] = staged_q[gi];
                if (wr_en && (slot == 3'(gi))) begin
                    staged_d[gi] = card_i;
                end
            end

            assign active_cards_o[8*gi +: 8] = active_q[gi];
        end
    endgenerate

    // Read path: registered readback of the pre-write staged value.
    always_comb begin
        card_d = staged_q[slot];
    end

    // Commit walk controller: IDLE -> SCAN (8 slots) -> DONE, with one collapsed pending request.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pending_d  = pending_q;
        done_d     = 1'b0;
        chg_d      = 1'b0;
        chg_slot_d = chg_slot_q;
        chg_card_d = chg_card_q;
        for (int s = 0; s < 8; s++) begin
            active_d[s] = active_q[s];
        end

        case (state_q)
            S_IDLE: begin
                if (reconfig || pending_q) begin
                    state_d   = S_SCAN;
                    idx_d     = 3'd0;
                    pending_d = 1'b0;
                end
            end
            S_SCAN: begin
                active_d[idx_q] = scan_src;
                if (scan_src != active_q[idx_q]) begin
                    chg_d      = 1'b1;
                    chg_slot_d = idx_q;
                    chg_card_d = scan_src;
                end
                if (reconfig) begin
                    pending_d = 1'b1;
                end
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
                if (pending_q || reconfig) begin
                    state_d   = S_SCAN;
                    idx_d     = 3'd0;
                    pending_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_SCAN);
    end

    // State registers; reset restores defaults and discards any partial commit.
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            for (int s = 0; s < 8; s++) begin
                staged_q[s] <= DEFAULT_CARDS[8*s +: 8];
                active_q[s] <= DEFAULT_CARDS[8*s +: 8];
            end
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            pending_q  <= 1'b0;
            card_q     <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            chg_q      <= 1'b0;
            chg_slot_q <= 3'd0;
            chg_card_q <= 8'h00;
        end else begin
            for (int s = 0; s < 8; s++) begin
                staged_q[s] <= staged_d[s];
                active_q[s] <= active_d[s];
            end
            state_q    <= state_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            card_q     <= card_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            chg_q      <= chg_d;
            chg_slot_q <= chg_slot_d;
            chg_card_q <= chg_card_d;
        end
    end

    assign card_o             = card_q;
    assign busy_o             = busy_q;
    assign commit_done_o      = done_q;
    assign slot_change_o      = chg_q;
    assign slot_change_slot_o = chg_slot_q;
    assign slot_change_card_o = chg_card_q;

endmodule
